// File: rtl/data_memory_pkg.sv
// Shared definitions for the block-organised data memory: geometry,
// latency counter width and FSM state encoding.
package data_memory_pkg;

    localparam int BLOCK_ADDR_W = 6;
    localparam int BLOCK_W      = 32;
    localparam int NUM_BLOCKS   = 64;
    localparam int CNT_W        = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// 64 x 32 block storage: one synchronous write port, one synchronous read
// port whose output register is the only resettable state.
module dmem_array
    import data_memory_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic                    re,
    input  logic [BLOCK_ADDR_W-1:0] addr,
    input  logic [BLOCK_W-1:0]      wdata,
    output logic [BLOCK_W-1:0]      rdata
);

    logic [BLOCK_W-1:0] mem [NUM_BLOCKS];

    // Array contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_memory.sv
// Fixed-latency block memory seen by the data cache: a request is latched in
// IDLE, counted down in BUSY, performed on the last BUSY edge, then DONE.
//
// Handshake: the cache raises exactly one of mem_read/mem_write and holds it
// until it samples mem_busywait low; the access uses values latched at
// acceptance, and the request still present during DONE is ignored.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int LATENCY = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [BLOCK_ADDR_W-1:0] mem_address,
    input  logic [BLOCK_W-1:0]      mem_writedata,
    output logic [BLOCK_W-1:0]      mem_readdata,
    output logic                    mem_busywait,
    output logic                    mem_error,
    output state_t                  state_dbg
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t                  state, next_state;
    logic [CNT_W-1:0]        cnt;
    logic [BLOCK_ADDR_W-1:0] addr_q;
    logic [BLOCK_W-1:0]      data_q;
    logic                    write_q;
    logic                    single_req;
    logic                    do_access;

    assign single_req = mem_read ^ mem_write;
    assign do_access  = !reset && (state == BUSY) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && single_req) begin
                cnt <= CNT_LOAD;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Request payload is captured only at acceptance, so later changes on
    // the cache side cannot disturb an access in flight.
    always_ff @(posedge clk) begin
        if (!reset && state == IDLE && single_req) begin
            addr_q  <= mem_address;
            data_q  <= mem_writedata;
            write_q <= mem_write;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (single_req) next_state = BUSY;
            BUSY:    if (cnt == '0)  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign mem_busywait = !reset && ((state == IDLE && single_req) || state == BUSY);
    assign mem_error    = !reset && (state == IDLE) && mem_read && mem_write;
    assign state_dbg    = state;

    dmem_array u_array (
        .clk   (clk),
        .reset (reset),
        .we    (do_access && write_q),
        .re    (do_access && !write_q),
        .addr  (addr_q),
        .wdata (data_q),
        .rdata (mem_readdata)
    );

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory at LATENCY 5, 1 and 15 with hand-computed
// expectations for latency, data, handshake, error and reset behaviour.
module tb_data_memory;
    import data_memory_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd    [3];
    logic        wr    [3];
    logic [5:0]  addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        busy  [3];
    logic        err   [3];
    state_t      st    [3];
    logic [31:0] last_rd [3];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    data_memory #(.LATENCY(5)) dut0 (
        .clk(clk), .reset(reset), .mem_read(rd[0]), .mem_write(wr[0]),
        .mem_address(addr[0]), .mem_writedata(wdata[0]), .mem_readdata(rdata[0]),
        .mem_busywait(busy[0]), .mem_error(err[0]), .state_dbg(st[0])
    );
    data_memory #(.LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .mem_read(rd[1]), .mem_write(wr[1]),
        .mem_address(addr[1]), .mem_writedata(wdata[1]), .mem_readdata(rdata[1]),
        .mem_busywait(busy[1]), .mem_error(err[1]), .state_dbg(st[1])
    );
    data_memory #(.LATENCY(15)) dut2 (
        .clk(clk), .reset(reset), .mem_read(rd[2]), .mem_write(wr[2]),
        .mem_address(addr[2]), .mem_writedata(wdata[2]), .mem_readdata(rdata[2]),
        .mem_busywait(busy[2]), .mem_error(err[2]), .state_dbg(st[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cache-style transaction: hold the request until busywait is seen low,
    // keep it through the DONE edge, then drop it.
    task automatic xfer(input int k, input bit is_wr, input logic [5:0] a,
                        input logic [31:0] d, input int lat, input bit move_addr,
                        input string tag);
        int n;
        addr[k]  = a;
        wdata[k] = d;
        rd[k]    = !is_wr;
        wr[k]    = is_wr;
        #1;
        chk({tag, "_busy_req"}, 32'(busy[k]), 32'd1);
        tick();
        chk({tag, "_busy_e0"}, 32'(busy[k]), 32'd1);
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (move_addr && n == 2) begin
                addr[k]  = 6'h00;
                wdata[k] = 32'hFFFF_0000;
            end
            if (!busy[k]) break;
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        if (!is_wr) last_rd[k] = d;
        chk({tag, "_rdata"}, rdata[k], last_rd[k]);
        chk({tag, "_state_done"}, 32'(st[k]), 32'(DONE));
        tick();
        rd[k] = 1'b0;
        wr[k] = 1'b0;
        #1;
        chk({tag, "_state_idle"}, 32'(st[k]), 32'(IDLE));
        chk({tag, "_busy_after"}, 32'(busy[k]), 32'd0);
        tick();
        chk({tag, "_no_retrigger"}, 32'(st[k]), 32'(IDLE));
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0; last_rd[k] = '0;
        end
        rd[0] = 1'b1;
        tick();
        tick();
        chk("rst_busy_masked", 32'(busy[0]), 32'd0);
        chk("rst_rdata", rdata[0], 32'h0);
        chk("rst_error", 32'(err[0]), 32'd0);
        chk("rst_state", 32'(st[0]), 32'(IDLE));
        rd[0] = 1'b0;
        reset = 1'b0;
        tick();

        // Write then read back at LATENCY 5.
        xfer(0, 1'b1, 6'h05, 32'hDEADBEEF, 5, 1'b0, "wr05");
        xfer(0, 1'b0, 6'h05, 32'hDEADBEEF, 5, 1'b0, "rd05");

        // Prior value for 0x0A, then a write killed by reset at E3.
        xfer(0, 1'b1, 6'h0A, 32'h1111_1111, 5, 1'b0, "wr0a");
        addr[0] = 6'h0A; wdata[0] = 32'h12345678; wr[0] = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rstmid_state", 32'(st[0]), 32'(IDLE));
        chk("rstmid_busy", 32'(busy[0]), 32'd0);
        chk("rstmid_rdata", rdata[0], 32'h0);
        wr[0] = 1'b0;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) last_rd[k] = '0;
        tick();
        xfer(0, 1'b0, 6'h0A, 32'h1111_1111, 5, 1'b0, "rd0a_prior");

        // Illegal request: read and write together.
        rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 6'h05; wdata[0] = 32'h0;
        #1;
        chk("err_pulse", 32'(err[0]), 32'd1);
        chk("err_busy", 32'(busy[0]), 32'd0);
        tick();
        chk("err_state", 32'(st[0]), 32'(IDLE));
        rd[0] = 1'b0; wr[0] = 1'b0;
        #1;
        chk("err_clear", 32'(err[0]), 32'd0);
        xfer(0, 1'b0, 6'h05, 32'hDEADBEEF, 5, 1'b0, "rd05_after_err");

        // Address/data changed mid-BUSY must not redirect the write.
        xfer(0, 1'b1, 6'h00, 32'h0BADF00D, 5, 1'b0, "wr00");
        xfer(0, 1'b1, 6'h10, 32'hAAAA5555, 5, 1'b1, "wr10_move");
        xfer(0, 1'b0, 6'h10, 32'hAAAA5555, 5, 1'b0, "rd10");
        xfer(0, 1'b0, 6'h00, 32'h0BADF00D, 5, 1'b0, "rd00");

        // Latency extremes and the top block address.
        xfer(1, 1'b1, 6'h3F, 32'hCAFEF00D, 1, 1'b0, "l1_wr3f");
        xfer(1, 1'b0, 6'h3F, 32'hCAFEF00D, 1, 1'b0, "l1_rd3f");
        xfer(2, 1'b1, 6'h3F, 32'h5A5A_A5A5, 15, 1'b0, "l15_wr3f");
        xfer(2, 1'b0, 6'h3F, 32'h5A5A_A5A5, 15, 1'b0, "l15_rd3f");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
